id_ex_stage: RTL and testbench

Decode-to-execute pipeline boundary of the pipelined CPU. It takes the decoder's D-stage control bundle and the register-file operands, registers them into the E stage, and inserts bubbles. It also owns the pipeline's hazard decisions: load-use stall, taken-branch flush, and ALU operand forwarding selects. Two saturating event counters support debugging.

---
 rtl/id_ex_stage_if.sv | 46 ++++
 rtl/id_ex_stage.sv | 116 +++++++++++
 tb/tb_id_ex_stage.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_if.sv
// D->E pipeline boundary bus.
// master: decode/hazard-source side (drives D bundle, M/W destinations),
//         observes E bundle, hazard controls and event counters.
// slave : the id_ex_stage itself.
interface id_ex_stage_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CNT_W  = 16
);
   // D-stage bundle
   logic              RegWriteD, MemtoRegD, MemWriteD, BranchD, ALUSrcD;
   logic [2:0]        ALUControlD;
   logic [DATA_W-1:0] RD1D, RD2D, ExtImmD;
   logic [3:0]        RA1D, RA2D, WA3D;
   // later-stage destinations for forwarding
   logic [3:0]        WA3M, WA3W;
   logic              RegWriteM, RegWriteW;
   // E-stage bundle
   logic              RegWriteE, MemtoRegE, MemWriteE, BranchE, ALUSrcE;
   logic [2:0]        ALUControlE;
   logic [DATA_W-1:0] RD1E, RD2E, ExtImmE;
   logic [3:0]        RA1E, RA2E, WA3E;
   // hazard controls and debug counters
   logic [1:0]        ForwardAE, ForwardBE;
   logic              StallF, StallD, FlushD;
   logic [CNT_W-1:0]  StallCount, FlushCount;

   modport master (
      output RegWriteD, MemtoRegD, MemWriteD, BranchD, ALUSrcD, ALUControlD,
             RD1D, RD2D, ExtImmD, RA1D, RA2D, WA3D,
             WA3M, WA3W, RegWriteM, RegWriteW,
      input  RegWriteE, MemtoRegE, MemWriteE, BranchE, ALUSrcE, ALUControlE,
             RD1E, RD2E, ExtImmE, RA1E, RA2E, WA3E,
             ForwardAE, ForwardBE, StallF, StallD, FlushD,
             StallCount, FlushCount
   );

   modport slave (
      input  RegWriteD, MemtoRegD, MemWriteD, BranchD, ALUSrcD, ALUControlD,
             RD1D, RD2D, ExtImmD, RA1D, RA2D, WA3D,
             WA3M, WA3W, RegWriteM, RegWriteW,
      output RegWriteE, MemtoRegE, MemWriteE, BranchE, ALUSrcE, ALUControlE,
             RD1E, RD2E, ExtImmE, RA1E, RA2E, WA3E,
             ForwardAE, ForwardBE, StallF, StallD, FlushD,
             StallCount, FlushCount
   );
endinterface

// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register with hazard unit.
// Ports: clk, reset (async, active-low), bus (id_ex_stage_if.slave):
//   D bundle in, E bundle out (registered), M/W destinations in,
//   ForwardAE/BE, StallF/D, FlushD (combinational), Stall/FlushCount (registered).
module id_ex_stage #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CNT_W  = 16
) (
   input logic          clk,
   input logic          reset,
   id_ex_stage_if.slave bus
);

   logic              load_use, branch_taken, stall, flush_e;
   logic              reg_write_q, mem_to_reg_q, mem_write_q, branch_q, alu_src_q;
   logic [2:0]        alu_ctrl_q;
   logic [DATA_W-1:0] rd1_q, rd2_q, imm_q;
   logic [3:0]        ra1_q, ra2_q, wa3_q;
   logic [CNT_W-1:0]  stall_cnt_q, flush_cnt_q;

   // M beats W; a matching write enable is required for either source.
   function automatic logic [1:0] fwd_sel(input logic [3:0] ra,
                                          input logic       rw_m, input logic [3:0] wa_m,
                                          input logic       rw_w, input logic [3:0] wa_w);
      if (rw_m && (ra == wa_m))      return 2'b10;
      else if (rw_w && (ra == wa_w)) return 2'b01;
      else                           return 2'b00;
   endfunction

   // Hazard detection; a taken branch makes the D instruction wrong-path,
   // so it suppresses the load-use stall.
   always_comb begin
      load_use     = mem_to_reg_q & reg_write_q &
                     ((bus.RA1D == wa3_q) | (bus.RA2D == wa3_q));
      branch_taken = branch_q;
      stall        = load_use & ~branch_taken;
      flush_e      = load_use | branch_taken;
   end

   // E register: loads D every cycle, or a zero bubble when flushed.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         reg_write_q  <= 1'b0;
         mem_to_reg_q <= 1'b0;
         mem_write_q  <= 1'b0;
         branch_q     <= 1'b0;
         alu_src_q    <= 1'b0;
         alu_ctrl_q   <= 3'd0;
         rd1_q        <= '0;
         rd2_q        <= '0;
         imm_q        <= '0;
         ra1_q        <= 4'd0;
         ra2_q        <= 4'd0;
         wa3_q        <= 4'd0;
      end else if (flush_e) begin
         reg_write_q  <= 1'b0;
         mem_to_reg_q <= 1'b0;
         mem_write_q  <= 1'b0;
         branch_q     <= 1'b0;
         alu_src_q    <= 1'b0;
         alu_ctrl_q   <= 3'd0;
         rd1_q        <= '0;
         rd2_q        <= '0;
         imm_q        <= '0;
         ra1_q        <= 4'd0;
         ra2_q        <= 4'd0;
         wa3_q        <= 4'd0;
      end else begin
         reg_write_q  <= bus.RegWriteD;
         mem_to_reg_q <= bus.MemtoRegD;
         mem_write_q  <= bus.MemWriteD;
         branch_q     <= bus.BranchD;
         alu_src_q    <= bus.ALUSrcD;
         alu_ctrl_q   <= bus.ALUControlD;
         rd1_q        <= bus.RD1D;
         rd2_q        <= bus.RD2D;
         imm_q        <= bus.ExtImmD;
         ra1_q        <= bus.RA1D;
         ra2_q        <= bus.RA2D;
         wa3_q        <= bus.WA3D;
      end
   end

   // Saturating hazard event counters.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (stall && (stall_cnt_q != '1))        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         if (branch_taken && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
   end

   assign bus.RegWriteE   = reg_write_q;
   assign bus.MemtoRegE   = mem_to_reg_q;
   assign bus.MemWriteE   = mem_write_q;
   assign bus.BranchE     = branch_q;
   assign bus.ALUSrcE     = alu_src_q;
   assign bus.ALUControlE = alu_ctrl_q;
   assign bus.RD1E        = rd1_q;
   assign bus.RD2E        = rd2_q;
   assign bus.ExtImmE     = imm_q;
   assign bus.RA1E        = ra1_q;
   assign bus.RA2E        = ra2_q;
   assign bus.WA3E        = wa3_q;

   assign bus.StallF      = stall;
   assign bus.StallD      = stall;
   assign bus.FlushD      = branch_taken;
   assign bus.ForwardAE   = fwd_sel(ra1_q, bus.RegWriteM, bus.WA3M, bus.RegWriteW, bus.WA3W);
   assign bus.ForwardBE   = fwd_sel(ra2_q, bus.RegWriteM, bus.WA3M, bus.RegWriteW, bus.WA3W);
   assign bus.StallCount  = stall_cnt_q;
   assign bus.FlushCount  = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus random traffic
// against a transaction-level model of the D->E boundary.
module tb_id_ex_stage;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned CNT_W  = 10;   // small so saturation is reachable quickly
   localparam int          MAXC   = (1 << CNT_W) - 1;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;

   id_ex_stage_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();
   id_ex_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   // Model: the instruction sitting in E plus unbounded event tallies.
   typedef struct packed {
      logic              rw, m2r, mw, br, src;
      logic [2:0]        alu;
      logic [DATA_W-1:0] rd1, rd2, imm;
      logic [3:0]        ra1, ra2, wa3;
   } e_t;
   e_t m;
   int stall_n, flush_n;

   function automatic e_t dut_e();
      return '{bus.RegWriteE, bus.MemtoRegE, bus.MemWriteE, bus.BranchE, bus.ALUSrcE,
               bus.ALUControlE, bus.RD1E, bus.RD2E, bus.ExtImmE,
               bus.RA1E, bus.RA2E, bus.WA3E};
   endfunction

   function automatic e_t d_bundle();
      return '{bus.RegWriteD, bus.MemtoRegD, bus.MemWriteD, bus.BranchD, bus.ALUSrcD,
               bus.ALUControlD, bus.RD1D, bus.RD2D, bus.ExtImmD,
               bus.RA1D, bus.RA2D, bus.WA3D};
   endfunction

   // D instruction needs a register that an in-flight load in E has not produced yet.
   function automatic bit exp_load_use();
      return m.m2r && m.rw && (bus.RA1D == m.wa3 || bus.RA2D == m.wa3);
   endfunction

   function automatic bit exp_stall();
      return exp_load_use() && !m.br;
   endfunction

   function automatic logic [1:0] exp_fwd(input logic [3:0] ra);
      if (bus.RegWriteM && ra == bus.WA3M) return 2'b10;
      if (bus.RegWriteW && ra == bus.WA3W) return 2'b01;
      return 2'b00;
   endfunction

   function automatic logic [CNT_W-1:0] sat(input int n);
      return (n > MAXC) ? CNT_W'(MAXC) : CNT_W'(n);
   endfunction

   task automatic model_reset();
      m = '0;
      stall_n = 0;
      flush_n = 0;
   endtask

   // Advance model and DUT by one rising edge; sample #1 after it.
   task automatic tick();
      if (exp_stall()) stall_n++;
      if (m.br) flush_n++;
      if (exp_load_use() || m.br) m = '0;
      else                        m = d_bundle();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_d();
      bus.RegWriteD = 0; bus.MemtoRegD = 0; bus.MemWriteD = 0; bus.BranchD = 0; bus.ALUSrcD = 0;
      bus.ALUControlD = 3'd0; bus.RD1D = '0; bus.RD2D = '0; bus.ExtImmD = '0;
      bus.RA1D = 4'd0; bus.RA2D = 4'd0; bus.WA3D = 4'd0;
      bus.WA3M = 4'd0; bus.WA3W = 4'd0; bus.RegWriteM = 0; bus.RegWriteW = 0;
   endtask

   function automatic logic [3:0] pick_reg();
      int r = int'($urandom_range(0, 7));
      return (r == 7) ? 4'd15 : 4'(r);
   endfunction

   task automatic rand_inputs();
      bus.RegWriteD = 1'($urandom); bus.MemtoRegD = 1'($urandom); bus.MemWriteD = 1'($urandom);
      bus.BranchD = ($urandom_range(0, 5) == 0); bus.ALUSrcD = 1'($urandom);
      bus.ALUControlD = 3'($urandom); bus.RD1D = $urandom; bus.RD2D = $urandom; bus.ExtImmD = $urandom;
      bus.RA1D = pick_reg(); bus.RA2D = pick_reg(); bus.WA3D = pick_reg();
      bus.WA3M = pick_reg(); bus.WA3W = pick_reg();
      bus.RegWriteM = 1'($urandom); bus.RegWriteW = 1'($urandom);
   endtask

   task automatic drive_add();
      clear_d();
      bus.ALUControlD = 3'b000; bus.RegWriteD = 1; bus.RD1D = 5; bus.RD2D = 7;
      bus.RA1D = 4'd8; bus.RA2D = 4'd9; bus.WA3D = 4'd10;
   endtask

   task automatic test_reset();
      reset = 0;
      rand_inputs();
      #1;
      n_checks++;
      if (dut_e() !== e_t'('0)) begin n_fail++; $display("FAIL reset_e: got %h expected 0", dut_e()); end
      @(posedge clk); #1;
      n_checks++;
      if ({bus.StallF, bus.StallD, bus.FlushD} !== 3'b000) begin
         n_fail++; $display("FAIL reset_hazard: got %b expected 000", {bus.StallF, bus.StallD, bus.FlushD});
      end
      n_checks++;
      if (bus.StallCount !== '0 || bus.FlushCount !== '0 || dut_e() !== e_t'('0)) begin
         n_fail++; $display("FAIL reset_hold: stall_cnt=%0d flush_cnt=%0d e=%h expected zeros",
                            bus.StallCount, bus.FlushCount, dut_e());
      end
      model_reset();
      @(negedge clk);
      reset = 1;
      drive_add();
      tick();
      n_checks++;
      if (bus.ALUControlE !== 3'b000 || bus.RD1E !== 32'd5 || bus.RD2E !== 32'd7 || bus.RegWriteE !== 1'b1) begin
         n_fail++; $display("FAIL add_pass: got alu=%b rd1=%0d rd2=%0d rw=%b expected 000 5 7 1",
                            bus.ALUControlE, bus.RD1E, bus.RD2E, bus.RegWriteE);
      end
   endtask

   task automatic test_load_use();
      @(negedge clk);
      clear_d();
      bus.RegWriteD = 1; bus.MemtoRegD = 1; bus.WA3D = 4'd3; bus.RA1D = 4'd0; bus.RA2D = 4'd1;
      tick();
      @(negedge clk);
      clear_d();
      bus.RegWriteD = 1; bus.RA1D = 4'd3; bus.RA2D = 4'd5; bus.WA3D = 4'd6; bus.RD1D = 32'd11;
      #1;
      n_checks++;
      if ({bus.StallF, bus.StallD, bus.FlushD} !== 3'b110) begin
         n_fail++; $display("FAIL lu_stall: got %b expected 110", {bus.StallF, bus.StallD, bus.FlushD});
      end
      tick();
      n_checks++;
      if (bus.RegWriteE !== 1'b0 || bus.StallD !== 1'b0) begin
         n_fail++; $display("FAIL lu_bubble: got rw=%b stall=%b expected 0 0", bus.RegWriteE, bus.StallD);
      end
      tick();
      n_checks++;
      if (bus.RegWriteE !== 1'b1 || bus.RA1E !== 4'd3 || bus.WA3E !== 4'd6 || bus.RD1E !== 32'd11) begin
         n_fail++; $display("FAIL lu_dependent: got rw=%b ra1=%0d wa3=%0d rd1=%0d expected 1 3 6 11",
                            bus.RegWriteE, bus.RA1E, bus.WA3E, bus.RD1E);
      end
      n_checks++;
      if (bus.StallCount !== CNT_W'(1)) begin
         n_fail++; $display("FAIL lu_count: got %0d expected 1", bus.StallCount);
      end
   endtask

   task automatic test_branch();
      @(negedge clk);
      clear_d();
      bus.BranchD = 1; bus.RegWriteD = 1; bus.MemtoRegD = 1; bus.WA3D = 4'd7;
      tick();
      @(negedge clk);
      clear_d();
      bus.RegWriteD = 1; bus.RA1D = 4'd7; bus.RA2D = 4'd7;
      #1;
      n_checks++;
      if ({bus.StallF, bus.StallD, bus.FlushD} !== 3'b001) begin
         n_fail++; $display("FAIL br_priority: got %b expected 001", {bus.StallF, bus.StallD, bus.FlushD});
      end
      tick();
      n_checks++;
      if (bus.RegWriteE !== 1'b0 || bus.BranchE !== 1'b0 || bus.FlushD !== 1'b0) begin
         n_fail++; $display("FAIL br_bubble: got rw=%b br=%b flushd=%b expected 0 0 0",
                            bus.RegWriteE, bus.BranchE, bus.FlushD);
      end
      n_checks++;
      if (bus.FlushCount !== CNT_W'(1) || bus.StallCount !== CNT_W'(1)) begin
         n_fail++; $display("FAIL br_count: got flush=%0d stall=%0d expected 1 1", bus.FlushCount, bus.StallCount);
      end
   endtask

   task automatic test_forwarding();
      @(negedge clk);
      clear_d();
      bus.RA1D = 4'd2; bus.RA2D = 4'd4;
      tick();
      bus.WA3M = 4'd2; bus.RegWriteM = 1; bus.WA3W = 4'd2; bus.RegWriteW = 1;
      #1;
      n_checks++;
      if (bus.ForwardAE !== 2'b10 || bus.ForwardBE !== 2'b00) begin
         n_fail++; $display("FAIL fwd_m_prio: got A=%b B=%b expected 10 00", bus.ForwardAE, bus.ForwardBE);
      end
      bus.RegWriteM = 0;
      #1;
      n_checks++;
      if (bus.ForwardAE !== 2'b01) begin
         n_fail++; $display("FAIL fwd_w: got %b expected 01", bus.ForwardAE);
      end
      bus.WA3W = 4'd4;
      #1;
      n_checks++;
      if (bus.ForwardAE !== 2'b00 || bus.ForwardBE !== 2'b01) begin
         n_fail++; $display("FAIL fwd_b: got A=%b B=%b expected 00 01", bus.ForwardAE, bus.ForwardBE);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         rand_inputs();
         #1;
         n_checks++;
         if ({bus.StallF, bus.StallD, bus.FlushD, bus.ForwardAE, bus.ForwardBE} !==
             {exp_stall(), exp_stall(), m.br, exp_fwd(m.ra1), exp_fwd(m.ra2)}) begin
            n_fail++; $display("FAIL rnd_comb[%0d]: got %b expected %b", i,
               {bus.StallF, bus.StallD, bus.FlushD, bus.ForwardAE, bus.ForwardBE},
               {exp_stall(), exp_stall(), m.br, exp_fwd(m.ra1), exp_fwd(m.ra2)});
         end
         tick();
         n_checks++;
         if (dut_e() !== m) begin
            n_fail++; $display("FAIL rnd_e[%0d]: got %h expected %h", i, dut_e(), m);
         end
         n_checks++;
         if (bus.StallCount !== sat(stall_n) || bus.FlushCount !== sat(flush_n)) begin
            n_fail++; $display("FAIL rnd_cnt[%0d]: got %0d/%0d expected %0d/%0d", i,
                               bus.StallCount, bus.FlushCount, sat(stall_n), sat(flush_n));
         end
      end
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 4 * (MAXC + 1) && flush_n < MAXC + 4; i++) begin
         @(negedge clk);
         clear_d();
         bus.BranchD = 1;
         tick();
      end
      n_checks++;
      if (flush_n < MAXC + 4) begin
         n_fail++; $display("FAIL sat_budget: got %0d flushes expected at least %0d", flush_n, MAXC + 4);
      end
      n_checks++;
      if (bus.FlushCount !== CNT_W'(MAXC)) begin
         n_fail++; $display("FAIL sat_flush: got %0h expected %0h", bus.FlushCount, CNT_W'(MAXC));
      end
   endtask

   task automatic test_reset_mid_stall();
      @(negedge clk);
      clear_d();
      tick();
      @(negedge clk);
      clear_d();
      bus.RegWriteD = 1; bus.MemtoRegD = 1; bus.WA3D = 4'd3;
      tick();
      @(negedge clk);
      clear_d();
      bus.RegWriteD = 1; bus.RA1D = 4'd3;
      #1;
      n_checks++;
      if (bus.StallD !== 1'b1) begin
         n_fail++; $display("FAIL rms_pre: got stall=%b expected 1", bus.StallD);
      end
      #1;
      reset = 0;
      #1;
      n_checks++;
      if ({bus.StallF, bus.StallD, bus.FlushD} !== 3'b000 || dut_e() !== e_t'('0) ||
          bus.StallCount !== '0 || bus.FlushCount !== '0) begin
         n_fail++; $display("FAIL rms_clear: got hz=%b e=%h cnt=%0d/%0d expected zeros",
                            {bus.StallF, bus.StallD, bus.FlushD}, dut_e(), bus.StallCount, bus.FlushCount);
      end
      model_reset();
      @(negedge clk);
      reset = 1;
      drive_add();
      tick();
      n_checks++;
      if (dut_e() !== m || bus.RD1E !== 32'd5 || bus.RegWriteE !== 1'b1) begin
         n_fail++; $display("FAIL rms_resume: got %h expected %h", dut_e(), m);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      clear_d();
      model_reset();
      test_reset();
      test_load_use();
      test_branch();
      test_forwarding();
      test_random();
      test_saturation();
      test_reset_mid_stall();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
